// File: rtl/pcla_pkg.sv
// Shared types and the parameter check for the pipelined carry-lookahead adder.
package pcla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } pcla_op_t;

  // Pipeline depth for a given split; 0 flags an illegal parameter combination.
  function automatic int pcla_lat(input int width, input int block, input int gps);
    if (block < 1 || gps < 1 || width < 1) return 0;
    if ((width % (block * gps)) != 0) return 0;
    return width / (block * gps);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// One BLOCK-bit carry-lookahead group: bit sums plus group propagate/generate.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             p,
  output logic             g,
  output logic             c_out
);

  logic [BLOCK-1:0] pb;
  logic [BLOCK-1:0] gb;
  logic [BLOCK-1:0] c;

  always_comb begin
    pb = a ^ b;
    gb = a & b;
    c  = '0;
    c[0] = c_in;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = gb[i-1] | (pb[i-1] & c[i-1]);
    end
    s = pb ^ c;
    p = &pb;
    g = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      g = gb[i] | (pb[i] & g);
    end
    c_out = g | (p & c_in);
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, GPS lookahead groups per stage, valid/ready on both sides.
// Define PCLA_SAT_EN to saturate the result on signed overflow instead of wrapping.
module pipelined_cla_adder
  import pcla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SL  = BLOCK * GPS;
  localparam int LAT = pcla_lat(WIDTH, BLOCK, GPS);

  if (LAT < 1) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK*GPS");
  end

  // Handshake: a beat moves into stage k when en[k] is high and the source is valid.
  // en[k] = !v[k] || en[k+1] with en[LAT] = out_ready, flattened so each bit only
  // depends on the valid bits at and after it.
  logic [LAT-1:0]   v;
  logic [LAT:0]     en;
  logic [WIDTH-1:0] b_eff;

  assign b_eff    = (pcla_op_t'(op) == OP_SUB) ? ~b : b;
  assign en[LAT]  = out_ready;
  assign in_ready = en[0];

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int REM = WIDTH - k * SL;

    logic [REM-1:0]      src_a;
    logic [REM-1:0]      src_b;
    logic                src_c;
    logic                src_v;
    logic [GPS:0]        c;
    logic [GPS-1:0]      gp;
    logic [GPS-1:0]      gg;
    logic [GPS-1:0]      gco;
    logic [SL-1:0]       slice_s;
    logic [(k+1)*SL-1:0] s_cat;
    logic [(k+1)*SL-1:0] s_d;
    logic                v_q;
    logic                c_q;
    logic [(k+1)*SL-1:0] s_q;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = cin;
      assign src_v = in_valid;
      assign s_cat = slice_s;
    end else begin : g_link
      assign src_a = g_stg[k-1].g_skew.a_q;
      assign src_b = g_stg[k-1].g_skew.b_q;
      assign src_c = g_stg[k-1].c_q;
      assign src_v = v[k-1];
      assign s_cat = {slice_s, g_stg[k-1].s_q};
    end

    assign v[k]  = v_q;
    assign en[k] = out_ready || !(&v[LAT-1:k]);
    assign c[0]  = src_c;

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a    (src_a[j*BLOCK +: BLOCK]),
        .b    (src_b[j*BLOCK +: BLOCK]),
        .c_in (c[j]),
        .s    (slice_s[j*BLOCK +: BLOCK]),
        .p    (gp[j]),
        .g    (gg[j]),
        .c_out(gco[j])
      );
      // Second-level lookahead across the groups of this stage.
      assign c[j+1] = gg[j] | (gp[j] & c[j]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en[k]) begin
        v_q <= src_v;
        if (src_v) begin
          c_q <= c[GPS];
          s_q <= s_d;
        end
      end
    end

    if (k < LAT - 1) begin : g_skew
      logic [REM-SL-1:0] a_q;
      logic [REM-SL-1:0] b_q;

      assign s_d = s_cat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en[k] && src_v) begin
          a_q <= src_a[REM-1:SL];
          b_q <= src_b[REM-1:SL];
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_n;
      logic ovf_q;
      logic zero_q;

      // Carry into the MSB recovered from its sum bit and operand bits.
      assign c_msb = slice_s[SL-1] ^ src_a[SL-1] ^ src_b[SL-1];
      assign ovf_n = c_msb ^ c[GPS];

`ifdef PCLA_SAT_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
      assign s_d = ovf_n ? (src_a[SL-1] ? SAT_MIN : SAT_MAX) : s_cat;
`else
      assign s_d = s_cat;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (en[k] && src_v) begin
          ovf_q  <= ovf_n;
          zero_q <= (s_d == '0);
        end
      end

      assign out_valid = v_q;
      assign sum       = s_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
      assign zero      = zero_q;
    end
  end

endmodule
